button_event_queue: RTL and testbench

Memory-mapped input front end feeding the Tetris processor core: synchronizes and debounces the raw game buttons and turns each press into a queued event code. The processor drains the queue with a load from its input-port address, one event per read. The block sits directly upstream of the processor's data-memory read mux. It decouples human-speed button activity from the game loop's polling rate.

---
 rtl/tetris_io_pkg.sv | 18 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/button_event_queue.sv | 126 ++++++++++++
 tb/tb_button_event_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tetris_io_pkg.sv
// rtl/tetris_io_pkg.sv - shared codes and read-word layout for the button event queue
// Purpose: event codes for the game buttons and bit positions inside the
//          processor-visible read word.
package tetris_io_pkg;

  typedef enum logic [7:0] {
    BTN_LEFT  = 8'd0,
    BTN_RIGHT = 8'd1,
    BTN_ROT   = 8'd2,
    BTN_DROP  = 8'd3
  } btn_code_e;

  localparam int RD_VALID    = 31;
  localparam int RD_OVF      = 30;
  localparam int RD_CODE_MSB = 7;
  localparam int CODE_W      = RD_CODE_MSB + 1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchronizer, debouncer and press pulse
// Purpose: bring one raw button into the clock domain, accept a level change
//          only after it has been stable long enough, and pulse on acceptance
//          of a press.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   btn    raw asynchronous button level, 1 = pressed
//   rise   one-cycle registered pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The increment that would make the count reach DEBOUNCE_CYCLES-1 is the
  // one that accepts the new level, so compare against one below that.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - debounced button press events queued for processor reads
// Purpose: turn debounced button presses into event codes held in a FIFO that
//          the processor drains one entry per load.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   btn_in    raw button levels, 1 = pressed
//   rd_en     one-cycle pop strobe from the load decode
//   rd_data   registered read word {valid, overflow, 22'b0, code[7:0]}
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   overflow  sticky flag: a press was lost
module button_event_queue
  import tetris_io_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEPTH           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               empty,
  output logic               full,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] sel;
  logic [NUM_BTN-1:0] grant_vec;
  logic [NUM_BTN-1:0] lost;
  logic               found;
  logic               push;
  logic               ovf_event;
  logic [CODE_W-1:0]  grant_idx;
  logic [31:0]        rd_next;

  logic [CODE_W-1:0]  mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_in[g]),
      .rise (rise[g])
    );
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Fixed-priority arbiter: lowest pending index wins one push per cycle.
  always_comb begin
    sel       = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pending[i] && !found) begin
        found     = 1'b1;
        grant_idx = CODE_W'(i);
        sel[i]    = 1'b1;
      end
    end
    push      = found && !full;
    grant_vec = {NUM_BTN{push}} & sel;
  end

  // A new press on a button whose earlier press is still waiting (and not
  // being pushed this cycle) cannot be recorded.
  assign lost      = rise & pending & ~grant_vec;
  assign ovf_event = |lost;

  always_comb begin
    rd_next           = '0;
    rd_next[RD_VALID] = !empty;
    rd_next[RD_OVF]   = overflow;
    if (!empty) begin
      rd_next[RD_CODE_MSB:0] = mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pending <= (pending & ~grant_vec) | rise;

      if (push) begin
        mem[wr_ptr[AW-1:0]] <= grant_idx;
        wr_ptr              <= wr_ptr + 1'b1;
      end

      if (rd_en) begin
        rd_data <= rd_next;
        if (!empty) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end

      // A loss in the read cycle re-arms the flag after the read captured it.
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (rd_en) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_queue.sv
// tb/tb_button_event_queue.sv - directed self-checking bench for button_event_queue
module tb_button_event_queue;
  import tetris_io_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  btn_in;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic        overflow;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]  b;
    logic        r;
    logic [31:0] rd;
    logic        e;
    logic        f;
    logic        o;
  } vec_t;

  vec_t vt[$];

  button_event_queue #(
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_in  (btn_in),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive inputs 1 time unit after an edge, then wait for the next edge + 1.
  task automatic cyc(input logic [3:0] b, input logic r);
    btn_in = b;
    rd_en  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic [3:0] b, input logic r, input logic [31:0] rd,
                      input logic e, input logic f, input logic o);
    vec_t v;
    v.b = b; v.r = r; v.rd = rd; v.e = e; v.f = f; v.o = o;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] last;
    int code;
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    btn_in = 4'h0;
    rd_en  = 1'b0;

    // ---------------- reset held low, buttons toggling ----------------
    for (int i = 0; i < 6; i++) begin
      cyc(4'(i * 5 + 3), 1'b0);
      chk("rst rd_data", rd_data, 32'h0);
      chk("rst empty", 32'(empty), 32'd1);
      chk("rst full", 32'(full), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
    end
    btn_in = 4'h0;
    reset  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(4'h0, 1'b0);
      chk("post-rst empty", 32'(empty), 32'd1);
    end
    chk("post-rst rd_data", rd_data, 32'h0);

    // ---------------- table: clean press, bounce, simultaneous ----------------
    last = 32'h0;
    for (int i = 0; i < 10; i++) addv(4'h4, 1'b0, last, (i < 6), 1'b0, 1'b0);
    last = 32'h8000_0000 | 32'(BTN_ROT);
    addv(4'h0, 1'b1, last, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) addv(4'h0, 1'b0, last, 1'b1, 1'b0, 1'b0);
    // too-short pulse on button 0
    for (int i = 0; i < 10; i++) addv((i < 2) ? 4'h1 : 4'h0, 1'b0, last, 1'b1, 1'b0, 1'b0);
    // four-sample pulse on button 0 yields exactly one event
    for (int i = 0; i < 8; i++) addv((i < 4) ? 4'h1 : 4'h0, 1'b0, last, (i < 6), 1'b0, 1'b0);
    last = 32'h8000_0000 | 32'(BTN_LEFT);
    addv(4'h0, 1'b1, last, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) addv(4'h0, 1'b0, last, 1'b1, 1'b0, 1'b0);
    // buttons 3 and 1 together
    for (int i = 0; i < 8; i++) addv((i < 6) ? 4'hA : 4'h0, 1'b0, last, (i < 6), 1'b0, 1'b0);
    addv(4'h0, 1'b1, 32'h8000_0000 | 32'(BTN_RIGHT), 1'b0, 1'b0, 1'b0);
    last = 32'h8000_0000 | 32'(BTN_DROP);
    addv(4'h0, 1'b1, last, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) addv(4'h0, 1'b0, last, 1'b1, 1'b0, 1'b0);

    foreach (vt[i]) begin
      cyc(vt[i].b, vt[i].r);
      chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].rd);
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vt[i].e));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vt[i].f));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vt[i].o));
    end

    // ---------------- full queue and lost press ----------------
    for (int i = 0; i < 26; i++) begin
      logic [3:0] b;
      if (i < 5) b = 4'hF;
      else if ((i >= 10 && i < 15) || (i >= 20 && i < 25)) b = 4'h1;
      else b = 4'h0;
      cyc(b, 1'b0);
      if (i == 9) chk("fill full", 32'(full), 32'd1);
      if (i == 15) chk("pend blocked empty", 32'(empty), 32'd0);
      if (i == 15) chk("first press no ovf", 32'(overflow), 32'd0);
      if (i == 24) chk("ovf before second rise", 32'(overflow), 32'd0);
      if (i == 25) chk("ovf set", 32'(overflow), 32'd1);
      if (i == 25) chk("still full", 32'(full), 32'd1);
    end
    cyc(4'h0, 1'b0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    cyc(4'h0, 1'b1);
    chk("ovf pop rd_data", rd_data, 32'hC000_0000 | 32'(BTN_LEFT));
    chk("ovf cleared", 32'(overflow), 32'd0);
    chk("pop frees slot", 32'(full), 32'd0);
    cyc(4'h0, 1'b0);
    chk("pending pushed", 32'(full), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(4'h0, 1'b1);
      chk($sformatf("drain%0d rd_data", k), rd_data, 32'h8000_0000 | 32'(k % 4));
    end
    chk("drain empty", 32'(empty), 32'd1);

    // ---------------- empty read ----------------
    cyc(4'h0, 1'b1);
    chk("empty read rd_data", rd_data, 32'h0);
    chk("empty read empty", 32'(empty), 32'd1);

    // ---------------- push/pop pairs across pointer wrap ----------------
    for (int k = 0; k < 10; k++) begin
      code = (k * 3 + 2) % 4;
      for (int r = 0; r < 10; r++) begin
        cyc((r < 5) ? 4'(1 << code) : 4'h0, (r == 7));
        if (r == 6) begin
          chk($sformatf("wrap%0d empty", k), 32'(empty), 32'd0);
          chk($sformatf("wrap%0d full", k), 32'(full), 32'd0);
        end
        if (r == 7) begin
          chk($sformatf("wrap%0d rd_data", k), rd_data, 32'h8000_0000 | 32'(code));
          chk($sformatf("wrap%0d empty after pop", k), 32'(empty), 32'd1);
        end
      end
    end

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 8; i++) cyc((i < 5) ? 4'h2 : 4'h0, 1'b0);
    chk("pre-async queued", 32'(empty), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async empty", 32'(empty), 32'd1);
    chk("async rd_data", rd_data, 32'h0);
    cyc(4'h0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(4'h0, 1'b0);
      chk("after async empty", 32'(empty), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
